// File: rtl/crush_controller_if.sv
// Codec-side bundle for the crush controller: sample handshake, controls and status.
// The controller connects through the slave modport; the codec/driver side uses master.
interface crush_controller_if;
  logic        enable;
  logic        depth_up;
  logic        depth_down;
  logic [2:0]  rate_sel;
  logic        audio_in_available;
  logic        audio_out_allowed;
  logic [31:0] l_audio_in;
  logic [31:0] r_audio_in;
  logic        read_audio_in;
  logic        write_audio_out;
  logic [31:0] l_audio_out;
  logic [31:0] r_audio_out;
  logic [4:0]  crush_bits;
  logic        busy;

  modport master (
    output enable, depth_up, depth_down, rate_sel,
           audio_in_available, audio_out_allowed, l_audio_in, r_audio_in,
    input  read_audio_in, write_audio_out, l_audio_out, r_audio_out,
           crush_bits, busy
  );

  modport slave (
    input  enable, depth_up, depth_down, rate_sel,
           audio_in_available, audio_out_allowed, l_audio_in, r_audio_in,
    output read_audio_in, write_audio_out, l_audio_out, r_audio_out,
           crush_bits, busy
  );
endinterface

// File: rtl/crush_controller.sv
// Bit-crush + sample-hold decimator, one stereo sample in flight; read at t, write at t+2.
// Output backpressure parks the FSM in WRITE with outputs held; input is only popped when output can accept.
module crush_controller #(
  parameter int DEPTH_DEFAULT = 8,
  parameter int DEPTH_MAX     = 24
) (
  input  logic             clk,
  input  logic             reset_n,
  crush_controller_if.slave bus
);

  typedef enum logic [1:0] {IDLE, PROC, WRITE} state_t;

  typedef struct packed {
    logic [31:0] l;
    logic [31:0] r;
  } sample_t;

  localparam logic [4:0]  DEPTH_RST = 5'(DEPTH_DEFAULT);
  localparam logic [4:0]  DEPTH_TOP = 5'(DEPTH_MAX);
  localparam logic [31:0] ONES      = '1;

  state_t      state_q, state_d;
  sample_t     in_q, in_d;
  sample_t     out_q, out_d;
  sample_t     held_q, held_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [4:0]  depth_q, depth_d;
  logic        rd, wr;
  logic [31:0] mask;
  sample_t     crushed;

  assign mask      = ONES << depth_q;
  assign crushed.l = in_q.l & mask;
  assign crushed.r = in_q.r & mask;

  always_comb begin
    state_d = state_q;
    in_d    = in_q;
    out_d   = out_q;
    held_d  = held_q;
    cnt_d   = cnt_q;
    rd      = 1'b0;
    wr      = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.audio_in_available && bus.audio_out_allowed) begin
          rd      = 1'b1;
          in_d.l  = bus.l_audio_in;
          in_d.r  = bus.r_audio_in;
          state_d = PROC;
        end
      end
      PROC: begin
        if (!bus.enable) begin
          out_d  = in_q;
          held_d = in_q;
          cnt_d  = 3'd0;
        end else if (cnt_q == 3'd0) begin
          out_d  = crushed;
          held_d = crushed;
          cnt_d  = bus.rate_sel;
        end else begin
          out_d  = held_q;
          cnt_d  = cnt_q - 3'd1;
        end
        state_d = WRITE;
      end
      WRITE: begin
        if (bus.audio_out_allowed) begin
          wr      = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Simultaneous up/down cancel; each direction saturates at its bound.
  always_comb begin
    depth_d = depth_q;
    if (bus.depth_up && !bus.depth_down && depth_q != DEPTH_TOP)
      depth_d = depth_q + 5'd1;
    else if (bus.depth_down && !bus.depth_up && depth_q != 5'd0)
      depth_d = depth_q - 5'd1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      in_q    <= '0;
      out_q   <= '0;
      held_q  <= '0;
      cnt_q   <= 3'd0;
      depth_q <= DEPTH_RST;
    end else begin
      state_q <= state_d;
      in_q    <= in_d;
      out_q   <= out_d;
      held_q  <= held_d;
      cnt_q   <= cnt_d;
      depth_q <= depth_d;
    end
  end

  assign bus.read_audio_in   = rd;
  assign bus.write_audio_out = wr;
  assign bus.l_audio_out     = out_q.l;
  assign bus.r_audio_out     = out_q.r;
  assign bus.crush_bits      = depth_q;
  assign bus.busy            = (state_q != IDLE);

endmodule

// File: tb/tb_crush_controller.sv
// Directed bench for crush_controller: crush, passthrough, depth saturation, decimation,
// backpressure and reset during WRITE.
module tb_crush_controller;
  logic clk = 1'b0;
  logic reset_n;
  int   checks   = 0;
  int   failures = 0;

  crush_controller_if bus();

  crush_controller #(.DEPTH_DEFAULT(8), .DEPTH_MAX(24)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One sample with both handshakes high; checks strobe timing and returns outputs.
  task automatic send(input logic [31:0] l, input logic [31:0] r,
                      output logic [31:0] lo, output logic [31:0] ro);
    @(negedge clk);
    bus.l_audio_in         = l;
    bus.r_audio_in         = r;
    bus.audio_in_available = 1'b1;
    bus.audio_out_allowed  = 1'b1;
    #1;
    check_val("rd_t0", 32'(bus.read_audio_in), 32'd1);
    check_val("wr_t0", 32'(bus.write_audio_out), 32'd0);
    @(negedge clk);
    bus.audio_in_available = 1'b0;
    check_val("rd_t1", 32'(bus.read_audio_in), 32'd0);
    check_val("wr_t1", 32'(bus.write_audio_out), 32'd0);
    check_val("busy_t1", 32'(bus.busy), 32'd1);
    @(negedge clk);
    check_val("wr_t2", 32'(bus.write_audio_out), 32'd1);
    check_val("rd_t2", 32'(bus.read_audio_in), 32'd0);
    lo = bus.l_audio_out;
    ro = bus.r_audio_out;
    @(negedge clk);
    check_val("busy_done", 32'(bus.busy), 32'd0);
  endtask

  task automatic pulse(input logic up, input logic dn);
    @(negedge clk);
    bus.depth_up   = up;
    bus.depth_down = dn;
    @(negedge clk);
    bus.depth_up   = 1'b0;
    bus.depth_down = 1'b0;
  endtask

  logic [31:0] lo, ro;
  logic [31:0] dec_exp [7];
  int          wr_seen;

  initial begin
    dec_exp = '{32'd1, 32'd1, 32'd1, 32'd4, 32'd4, 32'd4, 32'd7};
    reset_n                = 1'b0;
    bus.enable             = 1'b1;
    bus.depth_up           = 1'b0;
    bus.depth_down         = 1'b0;
    bus.rate_sel           = 3'd0;
    bus.audio_in_available = 1'b0;
    bus.audio_out_allowed  = 1'b0;
    bus.l_audio_in         = '0;
    bus.r_audio_in         = '0;
    #12;
    check_val("rst_lout", bus.l_audio_out, 32'd0);
    check_val("rst_rout", bus.r_audio_out, 32'd0);
    check_val("rst_depth", 32'(bus.crush_bits), 32'd8);
    check_val("rst_busy", 32'(bus.busy), 32'd0);
    check_val("rst_rd", 32'(bus.read_audio_in), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // Basic crush at depth 8
    send(32'h1234_5678, 32'hFFFF_FFFF, lo, ro);
    check_val("crush_l", lo, 32'h1234_5600);
    check_val("crush_r", ro, 32'hFFFF_FF00);

    // Passthrough
    bus.enable = 1'b0;
    send(32'h0000_00FF, 32'h8000_0001, lo, ro);
    check_val("pass_l", lo, 32'h0000_00FF);
    check_val("pass_r", ro, 32'h8000_0001);

    // Depth saturation
    for (int i = 0; i < 20; i++) pulse(1'b1, 1'b0);
    check_val("depth_max", 32'(bus.crush_bits), 32'd24);
    for (int i = 0; i < 30; i++) pulse(1'b0, 1'b1);
    check_val("depth_min", 32'(bus.crush_bits), 32'd0);
    pulse(1'b1, 1'b0);
    check_val("depth_one", 32'(bus.crush_bits), 32'd1);
    pulse(1'b1, 1'b1);
    check_val("depth_both", 32'(bus.crush_bits), 32'd1);
    pulse(1'b0, 1'b1);
    check_val("depth_zero", 32'(bus.crush_bits), 32'd0);

    // Decimation, hold factor 3
    bus.enable   = 1'b1;
    bus.rate_sel = 3'd2;
    for (int i = 0; i < 7; i++) begin
      send(32'(i + 1), 32'(i + 101), lo, ro);
      check_val("dec_l", lo, dec_exp[i]);
      check_val("dec_r", ro, dec_exp[i] + 32'd100);
    end

    // Backpressure in WRITE (passthrough for a clean expected value)
    bus.enable = 1'b0;
    @(negedge clk);
    bus.l_audio_in         = 32'hAAAA_5555;
    bus.r_audio_in         = 32'h0F0F_F0F0;
    bus.audio_in_available = 1'b1;
    bus.audio_out_allowed  = 1'b1;
    #1;
    check_val("bp_rd", 32'(bus.read_audio_in), 32'd1);
    @(negedge clk);
    bus.audio_in_available = 1'b0;
    bus.audio_out_allowed  = 1'b0;
    wr_seen = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (bus.write_audio_out) wr_seen++;
      check_val("bp_busy", 32'(bus.busy), 32'd1);
    end
    check_val("bp_no_wr", 32'(wr_seen), 32'd0);
    check_val("bp_hold_l", bus.l_audio_out, 32'hAAAA_5555);
    bus.audio_out_allowed = 1'b1;
    #1;
    check_val("bp_wr", 32'(bus.write_audio_out), 32'd1);
    @(negedge clk);
    check_val("bp_idle", 32'(bus.busy), 32'd0);
    check_val("bp_wr_off", 32'(bus.write_audio_out), 32'd0);
    check_val("bp_stable_r", bus.r_audio_out, 32'h0F0F_F0F0);

    // Reset while parked in WRITE
    @(negedge clk);
    bus.l_audio_in         = 32'h1111_2222;
    bus.audio_in_available = 1'b1;
    @(negedge clk);
    bus.audio_in_available = 1'b0;
    bus.audio_out_allowed  = 1'b0;
    @(negedge clk);
    check_val("rw_in_write", 32'(bus.busy), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check_val("rw_lout", bus.l_audio_out, 32'd0);
    check_val("rw_rout", bus.r_audio_out, 32'd0);
    check_val("rw_depth", 32'(bus.crush_bits), 32'd8);
    check_val("rw_busy", 32'(bus.busy), 32'd0);
    check_val("rw_wr", 32'(bus.write_audio_out), 32'd0);
    @(negedge clk);
    reset_n               = 1'b1;
    bus.audio_out_allowed = 1'b1;
    wr_seen = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (bus.write_audio_out) wr_seen++;
    end
    check_val("rw_no_wr", 32'(wr_seen), 32'd0);

    // Fresh sample after reset: depth 8, counter cleared
    bus.enable   = 1'b1;
    bus.rate_sel = 3'd0;
    send(32'hCAFE_BABE, 32'h0000_01FF, lo, ro);
    check_val("post_l", lo, 32'hCAFE_BA00);
    check_val("post_r", ro, 32'h0000_0100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
